// File: rtl/sflash_reader_if.sv
// Request and engine-side signal bundle for the SPI flash read sequencer.
// The slave modport is the sequencer; master is whatever drives it (requester plus byte engine).
interface sflash_reader_if #(
  parameter int unsigned LENW = 12
);
  // Requester side
  logic            start;
  logic [23:0]     addr;
  logic [LENW-1:0] len;
  logic            abort;
  logic            busy;
  logic            done;
  logic [7:0]      rdata;
  logic            rvalid;
  // Byte engine side
  logic            f_ready;
  logic            f_wr;
  logic [7:0]      f_din;
  logic [2:0]      f_format;
  logic [7:0]      f_dout;

  modport master (
    output start, addr, len, abort, f_ready, f_dout,
    input  busy, done, rdata, rvalid, f_wr, f_din, f_format
  );

  modport slave (
    input  start, addr, len, abort, f_ready, f_dout,
    output busy, done, rdata, rvalid, f_wr, f_din, f_format
  );
endinterface

// File: rtl/sflash_reader.sv
// SPI flash read sequencer: issues command, 24-bit address, optional dummy byte and N data
// bytes through the byte engine, streams the data bytes out, then holds CS# high.
module sflash_reader #(
  parameter bit          FAST = 1'b1,
  parameter int unsigned LENW = 12,
  parameter int unsigned CSHI = 4
) (
  input logic            clk,
  input logic            arstn,
  sflash_reader_if.slave bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCmd   = 3'd1;
  localparam logic [2:0] StA2    = 3'd2;
  localparam logic [2:0] StA1    = 3'd3;
  localparam logic [2:0] StA0    = 3'd4;
  localparam logic [2:0] StDummy = 3'd5;
  localparam logic [2:0] StData  = 3'd6;
  localparam logic [2:0] StCsh   = 3'd7;

  // Byte phases: wait to issue, strobe cycle, blind cycle, wait for completion
  localparam logic [1:0] PhIssue  = 2'd0;
  localparam logic [1:0] PhStrobe = 2'd1;
  localparam logic [1:0] PhSkip   = 2'd2;
  localparam logic [1:0] PhWait   = 2'd3;

  localparam logic [2:0] FmtIdle = 3'b000;
  localparam logic [2:0] FmtSdr  = 3'b010;
  localparam logic [7:0] CmdByte = FAST ? 8'h0B : 8'h03;
  localparam int unsigned CW     = (CSHI > 1) ? $clog2(CSHI) : 1;

  logic [2:0]      state_q, state_d;
  logic [1:0]      ph_q, ph_d;
  logic [23:0]     addr_q, addr_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rvalid_q, rvalid_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            f_wr_q, f_wr_d;
  logic [7:0]      f_din_q, f_din_d;
  logic [2:0]      f_format_q, f_format_d;

  logic            abort_now;
  logic            byte_last;
  logic [2:0]      state_nxt;

  function automatic logic [7:0] din_of(input logic [2:0] st, input logic [23:0] a);
    case (st)
      StCmd:   return CmdByte;
      StA2:    return a[23:16];
      StA1:    return a[15:8];
      StA0:    return a[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] next_of(input logic [2:0] st);
    case (st)
      StCmd:   return StA2;
      StA2:    return StA1;
      StA1:    return StA0;
      StA0:    return FAST ? StDummy : StData;
      default: return StData;
    endcase
  endfunction

  // Next-state logic for the transaction sequencer and all registered outputs
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    f_wr_d     = 1'b0;
    f_din_d    = f_din_q;
    f_format_d = f_format_q;
    abort_now  = abort_q | bus.abort;
    byte_last  = 1'b0;
    state_nxt  = state_q;

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (bus.start && bus.len != '0) begin
          addr_d  = bus.addr;
          rem_d   = bus.len;
          busy_d  = 1'b1;
          state_d = StCmd;
          ph_d    = PhIssue;
        end
      end

      StCsh: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        if (bus.abort) abort_d = 1'b1;
        unique case (ph_q)
          // Only the first byte waits here; CS# goes low together with its strobe
          PhIssue: begin
            if (abort_now) begin
              state_d    = StCsh;
              cnt_d      = CW'(CSHI - 1);
              f_format_d = FmtIdle;
            end else if (bus.f_ready) begin
              f_wr_d     = 1'b1;
              f_din_d    = din_of(state_q, addr_q);
              f_format_d = FmtSdr;
              ph_d       = PhStrobe;
            end
          end
          PhStrobe: ph_d = PhSkip;
          // Engine ready is not meaningful in the cycle right after the strobe
          PhSkip:   ph_d = PhWait;
          PhWait: begin
            if (bus.f_ready) begin
              if (state_q == StData) begin
                rem_d = rem_q - LENW'(1);
                if (!abort_now) begin
                  rdata_d  = bus.f_dout;
                  rvalid_d = 1'b1;
                end
                byte_last = (rem_q == LENW'(1)) || abort_now;
                state_nxt = StData;
              end else begin
                byte_last = abort_now;
                state_nxt = next_of(state_q);
              end
              if (byte_last) begin
                state_d    = StCsh;
                ph_d       = PhIssue;
                cnt_d      = CW'(CSHI - 1);
                f_format_d = FmtIdle;
              end else begin
                // Engine is idle and ready now, so the next byte goes out immediately
                state_d = state_nxt;
                f_wr_d  = 1'b1;
                f_din_d = din_of(state_nxt, addr_q);
                ph_d    = PhStrobe;
              end
            end
          end
          default: ph_d = PhIssue;
        endcase
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= StIdle;
      ph_q       <= PhIssue;
      addr_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      f_wr_q     <= 1'b0;
      f_din_q    <= '0;
      f_format_q <= FmtIdle;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      f_wr_q     <= f_wr_d;
      f_din_q    <= f_din_d;
      f_format_q <= f_format_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.f_wr     = f_wr_q;
  assign bus.f_din    = f_din_q;
  assign bus.f_format = f_format_q;

endmodule
